// File: rtl/bram_bank_array_if.sv
// Port bundle for the banked dual-port RAM array: per-bank A/B request lanes,
// read-data returns, collision flags and the clear-engine busy flag.
interface bram_bank_array_if #(
    parameter int unsigned BANKS   = 32,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDRESS = 10
);
    logic [BANKS-1:0]              ena;
    logic [BANKS-1:0]              enb;
    logic [BANKS-1:0]              wea;
    logic [BANKS-1:0]              web;
    logic [BANKS-1:0][ADDRESS-1:0] addra;
    logic [BANKS-1:0][ADDRESS-1:0] addrb;
    logic [BANKS-1:0][WIDTH-1:0]   dina;
    logic [BANKS-1:0][WIDTH-1:0]   dinb;
    logic [BANKS-1:0][WIDTH-1:0]   douta;
    logic [BANKS-1:0][WIDTH-1:0]   doutb;
    logic [BANKS-1:0]              vld_a;
    logic [BANKS-1:0]              vld_b;
    logic [BANKS-1:0]              collision;
    logic                          init_busy;

    modport master (
        output ena, enb, wea, web, addra, addrb, dina, dinb,
        input  douta, doutb, vld_a, vld_b, collision, init_busy
    );

    modport slave (
        input  ena, enb, wea, web, addra, addrb, dina, dinb,
        output douta, doutb, vld_a, vld_b, collision, init_busy
    );
endinterface

// File: rtl/bram_bank_array.sv
// Banked true-dual-port RAM array with post-reset clear engine, 1/2-cycle read
// latency, selectable read-during-write behaviour and A/B collision flagging.
module bram_bank_array #(
    parameter int unsigned BANKS      = 32,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDRESS    = 10,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic            clk,
    input  logic            rst,
    bram_bank_array_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDRESS;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ADDRESS-1:0] clr_cnt_q, clr_cnt_d;
    logic               init_busy_q, init_busy_d;

    logic [WIDTH-1:0] mem_q [BANKS][DEPTH];

    logic                        ready;
    logic [BANKS-1:0]            acc_a, acc_b, wr_a, wr_b, conflict;
    logic [BANKS-1:0][WIDTH-1:0] rd_a, rd_b;

    logic [BANKS-1:0]            vld_a1_q, vld_a1_d, vld_b1_q, vld_b1_d;
    logic [BANKS-1:0]            coll1_q, coll1_d;
    logic [BANKS-1:0][WIDTH-1:0] dout_a1_q, dout_a1_d, dout_b1_q, dout_b1_d;

    // Clear engine: sweep every address once, then hand the banks to the users.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_CLEAR: begin
                init_busy_d = 1'b1;
                clr_cnt_d   = clr_cnt_q + ADDRESS'(1);
                if (clr_cnt_q == {ADDRESS{1'b1}}) begin
                    state_d     = ST_READY;
                    init_busy_d = 1'b0;
                    clr_cnt_d   = '0;
                end
            end
            ST_READY: init_busy_d = 1'b0;
            default: begin
                state_d     = ST_READY;
                init_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q   <= '0;
            init_busy_q <= (INIT_CLEAR != 0);
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Access qualification and read data; the reading side of a conflict always
    // sees pre-write content because the array is read before this edge's write.
    always_comb begin
        ready    = (state_q == ST_READY) && !rst;
        acc_a    = bus.ena & {BANKS{ready}};
        acc_b    = bus.enb & {BANKS{ready}};
        wr_a     = acc_a & bus.wea;
        wr_b     = acc_b & bus.web;
        conflict = '0;
        rd_a     = '0;
        rd_b     = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            conflict[i] = acc_a[i] & acc_b[i] & (bus.addra[i] == bus.addrb[i])
                        & (wr_a[i] | wr_b[i]);
            rd_a[i] = ((RDW_MODE != 0) && wr_a[i]) ? bus.dina[i] : mem_q[i][bus.addra[i]];
            rd_b[i] = ((RDW_MODE != 0) && wr_b[i]) ? bus.dinb[i] : mem_q[i][bus.addrb[i]];
        end
    end

    // Port A is written last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BANKS; i++) begin
                if (state_q == ST_CLEAR) begin
                    mem_q[i][clr_cnt_q] <= '0;
                end else begin
                    if (wr_b[i]) mem_q[i][bus.addrb[i]] <= bus.dinb[i];
                    if (wr_a[i]) mem_q[i][bus.addra[i]] <= bus.dina[i];
                end
            end
        end
    end

    // First output stage: data registers hold until a new access lands.
    always_comb begin
        vld_a1_d  = acc_a;
        vld_b1_d  = acc_b;
        coll1_d   = conflict;
        dout_a1_d = dout_a1_q;
        dout_b1_d = dout_b1_q;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (acc_a[i]) dout_a1_d[i] = rd_a[i];
            if (acc_b[i]) dout_b1_d[i] = rd_b[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_a1_q  <= '0;
            vld_b1_q  <= '0;
            coll1_q   <= '0;
            dout_a1_q <= '0;
            dout_b1_q <= '0;
        end else begin
            vld_a1_q  <= vld_a1_d;
            vld_b1_q  <= vld_b1_d;
            coll1_q   <= coll1_d;
            dout_a1_q <= dout_a1_d;
            dout_b1_q <= dout_b1_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [BANKS-1:0]            vld_a2_q, vld_a2_d, vld_b2_q, vld_b2_d;
            logic [BANKS-1:0]            coll2_q, coll2_d;
            logic [BANKS-1:0][WIDTH-1:0] dout_a2_q, dout_a2_d, dout_b2_q, dout_b2_d;

            always_comb begin
                vld_a2_d  = vld_a1_q;
                vld_b2_d  = vld_b1_q;
                coll2_d   = coll1_q;
                dout_a2_d = dout_a2_q;
                dout_b2_d = dout_b2_q;
                for (int unsigned i = 0; i < BANKS; i++) begin
                    if (vld_a1_q[i]) dout_a2_d[i] = dout_a1_q[i];
                    if (vld_b1_q[i]) dout_b2_d[i] = dout_b1_q[i];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_a2_q  <= '0;
                    vld_b2_q  <= '0;
                    coll2_q   <= '0;
                    dout_a2_q <= '0;
                    dout_b2_q <= '0;
                end else begin
                    vld_a2_q  <= vld_a2_d;
                    vld_b2_q  <= vld_b2_d;
                    coll2_q   <= coll2_d;
                    dout_a2_q <= dout_a2_d;
                    dout_b2_q <= dout_b2_d;
                end
            end

            assign bus.douta     = dout_a2_q;
            assign bus.doutb     = dout_b2_q;
            assign bus.vld_a     = vld_a2_q;
            assign bus.vld_b     = vld_b2_q;
            assign bus.collision = coll2_q;
        end else begin : g_lat1
            assign bus.douta     = dout_a1_q;
            assign bus.doutb     = dout_b1_q;
            assign bus.vld_a     = vld_a1_q;
            assign bus.vld_b     = vld_b1_q;
            assign bus.collision = coll1_q;
        end
    endgenerate

    assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_bram_bank_array.sv
// Random plus directed stimulus on two array instances (lat1/read-first and
// lat2/write-first) checked every cycle against a word-level memory model.
module tb_bram_bank_array;
    localparam int unsigned BANKS   = 32;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ADDRESS = 10;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned VW      = 512;

    typedef struct packed {
        logic [BANKS-1:0]            va;
        logic [BANKS-1:0]            vb;
        logic [BANKS-1:0]            col;
        logic [BANKS-1:0][WIDTH-1:0] da;
        logic [BANKS-1:0][WIDTH-1:0] db;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [BANKS-1:0]              ena, enb, wea, web;
    logic [BANKS-1:0][ADDRESS-1:0] addra, addrb;
    logic [BANKS-1:0][WIDTH-1:0]   dina, dinb;

    bram_bank_array_if #(.BANKS(BANKS), .WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus0 ();
    bram_bank_array_if #(.BANKS(BANKS), .WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus1 ();

    assign bus0.ena = ena;   assign bus1.ena = ena;
    assign bus0.enb = enb;   assign bus1.enb = enb;
    assign bus0.wea = wea;   assign bus1.wea = wea;
    assign bus0.web = web;   assign bus1.web = web;
    assign bus0.addra = addra; assign bus1.addra = addra;
    assign bus0.addrb = addrb; assign bus1.addrb = addrb;
    assign bus0.dina = dina; assign bus1.dina = dina;
    assign bus0.dinb = dinb; assign bus1.dinb = dinb;

    bram_bank_array #(.BANKS(BANKS), .WIDTH(WIDTH), .ADDRESS(ADDRESS),
                      .RD_LAT(1), .RDW_MODE(0), .INIT_CLEAR(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    bram_bank_array #(.BANKS(BANKS), .WIDTH(WIDTH), .ADDRESS(ADDRESS),
                      .RD_LAT(2), .RDW_MODE(1), .INIT_CLEAR(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model: per-instance word arrays, clear countdown, result history.
    logic [WIDTH-1:0] mm [2][BANKS][DEPTH];
    res_t hist [2][4];
    res_t exp_o [2];
    logic exp_busy [2];
    int   busy_left [2];
    int   cyc;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int h = 0; h < 4; h++) hist[k][h] = '0;
            exp_o[k]     = '0;
            exp_busy[k]  = 1'b1;
            busy_left[k] = DEPTH;
        end
        cyc = 0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            res_t r;
            res_t o;
            int   lat;
            bit   wfirst;
            logic [WIDTH-1:0] olda, oldb;
            r      = '0;
            lat    = (k == 0) ? 1 : 2;
            wfirst = (k == 1);
            if (busy_left[k] > 0) begin
                busy_left[k]--;
                if (busy_left[k] == 0)
                    for (int b = 0; b < BANKS; b++)
                        for (int a = 0; a < DEPTH; a++) mm[k][b][a] = '0;
            end else begin
                for (int b = 0; b < BANKS; b++) begin
                    olda = mm[k][b][addra[b]];
                    oldb = mm[k][b][addrb[b]];
                    if (ena[b]) begin
                        r.va[b] = 1'b1;
                        r.da[b] = (wea[b] && wfirst) ? dina[b] : olda;
                    end
                    if (enb[b]) begin
                        r.vb[b] = 1'b1;
                        r.db[b] = (web[b] && wfirst) ? dinb[b] : oldb;
                    end
                    r.col[b] = ena[b] && enb[b] && (addra[b] == addrb[b]) && (wea[b] || web[b]);
                    if (enb[b] && web[b]) mm[k][b][addrb[b]] = dinb[b];
                    if (ena[b] && wea[b]) mm[k][b][addra[b]] = dina[b];
                end
            end
            hist[k][cyc % 4] = r;
            o = hist[k][(cyc + 4 - (lat - 1)) % 4];
            exp_o[k].va  = o.va;
            exp_o[k].vb  = o.vb;
            exp_o[k].col = o.col;
            for (int b = 0; b < BANKS; b++) begin
                if (o.va[b]) exp_o[k].da[b] = o.da[b];
                if (o.vb[b]) exp_o[k].db[b] = o.db[b];
            end
            exp_busy[k] = (busy_left[k] > 0);
        end
        cyc++;
    endtask

    task automatic check_all();
        check("d0_vld_a", VW'(bus0.vld_a),     VW'(exp_o[0].va));
        check("d0_vld_b", VW'(bus0.vld_b),     VW'(exp_o[0].vb));
        check("d0_coll",  VW'(bus0.collision), VW'(exp_o[0].col));
        check("d0_douta", VW'(bus0.douta),     VW'(exp_o[0].da));
        check("d0_doutb", VW'(bus0.doutb),     VW'(exp_o[0].db));
        check("d0_busy",  VW'(bus0.init_busy), VW'(exp_busy[0]));
        check("d1_vld_a", VW'(bus1.vld_a),     VW'(exp_o[1].va));
        check("d1_vld_b", VW'(bus1.vld_b),     VW'(exp_o[1].vb));
        check("d1_coll",  VW'(bus1.collision), VW'(exp_o[1].col));
        check("d1_douta", VW'(bus1.douta),     VW'(exp_o[1].da));
        check("d1_doutb", VW'(bus1.doutb),     VW'(exp_o[1].db));
        check("d1_busy",  VW'(bus1.init_busy), VW'(exp_busy[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        ena = '0; enb = '0; wea = '0; web = '0;
        addra = '0; addrb = '0; dina = '0; dinb = '0;
    endtask

    task automatic set_rand(input int arange, input int pen);
        for (int b = 0; b < BANKS; b++) begin
            ena[b]   = ($urandom_range(99) < 32'(pen));
            enb[b]   = ($urandom_range(99) < 32'(pen));
            wea[b]   = 1'($urandom_range(1));
            web[b]   = 1'($urandom_range(1));
            addra[b] = ADDRESS'($urandom_range(arange - 1));
            addrb[b] = ADDRESS'($urandom_range(arange - 1));
            dina[b]  = WIDTH'($urandom);
            dinb[b]  = WIDTH'($urandom);
        end
    endtask

    // Run a full clear with random enables and return how many cycles busy was high.
    task automatic run_clear(output int busy_cycles);
        busy_cycles = 0;
        repeat (DEPTH + 4) begin
            if (bus0.init_busy) busy_cycles++;
            set_rand(8, 70);
            tick();
        end
        set_idle();
    endtask

    initial begin
        int bc;
        int run;
        set_idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Clear with enables toggling: no vld, no writes, exact busy length
        run_clear(bc);
        check("t1_busy_len", VW'(bc), VW'(DEPTH));

        // Random traffic, narrow addresses to provoke conflicts and RDW
        repeat (400) begin set_rand(8, 60); tick(); end
        repeat (200) begin set_rand(DEPTH, 80); tick(); end
        set_idle();
        tick();

        // Write then read bank 3 addr 10
        ena[3] = 1'b1; wea[3] = 1'b1; addra[3] = 10; dina[3] = 16'hBEEF;
        tick();
        set_idle(); ena[3] = 1'b1; addra[3] = 10;
        tick();
        check("t2_lat1_data", VW'(bus0.douta[3]), VW'(16'hBEEF));
        check("t2_lat1_vld",  VW'(bus0.vld_a[3]), VW'(1'b1));
        set_idle();
        tick();
        check("t2_lat2_data", VW'(bus1.douta[3]), VW'(16'hBEEF));
        check("t2_lat2_vld",  VW'(bus1.vld_a[3]), VW'(1'b1));
        check("t2_lat1_idle", VW'(bus0.vld_a[3]), VW'(1'b0));

        // Same-port read-during-write on addr 7
        ena[0] = 1'b1; wea[0] = 1'b1; addra[0] = 7; dina[0] = 16'h1111;
        tick();
        dina[0] = 16'h2222;
        tick();
        check("t3_read_first", VW'(bus0.douta[0]), VW'(16'h1111));
        set_idle();
        tick();
        check("t3_write_first", VW'(bus1.douta[0]), VW'(16'h2222));
        ena[0] = 1'b1; addra[0] = 7;
        tick();
        check("t3_mem_rf", VW'(bus0.douta[0]), VW'(16'h2222));
        set_idle();
        tick();
        check("t3_mem_wf", VW'(bus1.douta[0]), VW'(16'h2222));

        // Double write collision in bank 0; same address in banks 1/2 is no conflict
        ena[0] = 1'b1; enb[0] = 1'b1; wea[0] = 1'b1; web[0] = 1'b1;
        addra[0] = 4; addrb[0] = 4; dina[0] = 16'hAAAA; dinb[0] = 16'h5555;
        ena[1] = 1'b1; wea[1] = 1'b1; addra[1] = 20; dina[1] = 16'h0101;
        enb[2] = 1'b1; web[2] = 1'b1; addrb[2] = 20; dinb[2] = 16'h0202;
        tick();
        check("t4_coll_lat1", VW'(bus0.collision), VW'(32'h1));
        set_idle();
        tick();
        check("t4_coll_pulse", VW'(bus0.collision), VW'(32'h0));
        check("t4_coll_lat2",  VW'(bus1.collision), VW'(32'h1));
        enb[0] = 1'b1; addrb[0] = 4;
        tick();
        check("t4_a_wins", VW'(bus0.doutb[0]), VW'(16'hAAAA));
        set_idle();
        tick();

        // Garbage in bank 5 top address, then reset mid-clear
        ena[5] = 1'b1; wea[5] = 1'b1; addra[5] = 10'd1023; dina[5] = 16'hDEAD;
        tick();
        set_idle();
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("t5_async_doutb", VW'(bus0.doutb), VW'(0));
        check("t5_async_busy",  VW'(bus0.init_busy), VW'(1'b1));
        tick();
        rst = 1'b0;
        repeat (500) begin set_rand(8, 70); tick(); end
        #2 rst = 1'b1;
        #1;
        check("t5_mid_busy", VW'(bus1.init_busy), VW'(1'b1));
        check("t5_mid_vld",  VW'(bus1.vld_a | bus1.vld_b), VW'(0));
        repeat (2) tick();
        rst = 1'b0;
        set_idle();
        run_clear(bc);
        check("t5_busy_len", VW'(bc), VW'(DEPTH));
        ena[5] = 1'b1; addra[5] = 10'd1023;
        tick();
        check("t1_cleared_lat1", VW'(bus0.douta[5]), VW'(0));
        set_idle();
        tick();
        check("t1_cleared_lat2", VW'(bus1.douta[5]), VW'(0));

        // Fill 0..63 in every bank, then stream port B reads
        for (int i = 0; i < 64; i++) begin
            set_idle();
            for (int b = 0; b < BANKS; b++) begin
                ena[b] = 1'b1; wea[b] = 1'b1;
                addra[b] = ADDRESS'(i);
                dina[b]  = WIDTH'((b << 8) | i);
            end
            tick();
        end
        set_idle();
        tick();
        run = 0;
        for (int i = 0; i < 68; i++) begin
            set_idle();
            if (i < 64) begin
                enb = '1;
                for (int b = 0; b < BANKS; b++) addrb[b] = ADDRESS'(i);
            end
            tick();
            if (bus1.vld_b == '1) begin
                check("t6_order", VW'(bus1.doutb[7]), VW'((7 << 8) | run));
                run++;
            end
        end
        check("t6_run", VW'(run), VW'(64));

        set_idle();
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
